// File: rtl/global_constants.sv
`default_nettype none
// global_constants -- project-wide constants shared between blocks.  rev 1.0
package global_constants;

  localparam int HS_TIMEOUT_DEFAULT = 50000;

endpackage
`default_nettype wire

// File: rtl/up_handshake_sequencer_pkg.sv
`default_nettype none
// up_handshake_sequencer_pkg -- state encoding and helpers for the uP handshake sequencer.  rev 1.0
package up_handshake_sequencer_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUS = 3'd1,
    S_ACK      = 3'd2,
    S_RELEASE  = 3'd3,
    S_FAULT    = 3'd4
  } seq_state_t;

  // The uP sees busy for as long as a transaction is owned by the sequencer.
  function automatic logic is_busy_state(input seq_state_t s);
    return (s == S_WAIT_BUS) || (s == S_ACK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// sync_ff -- single-bit multi-stage synchroniser for asynchronous uP strobes.  rev 1.0
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/up_handshake_sequencer.sv
`default_nettype none
// up_handshake_sequencer -- four-phase uP request/ack sequencer with watchdog and sticky fault.
// rev 1.0
module up_handshake_sequencer
  import up_handshake_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = global_constants::HS_TIMEOUT_DEFAULT,
  parameter int TMR_W          = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             uP_handshake_1,
  input  logic             uP_handshake_2,
  input  logic             bus_ready,
  input  logic             fault_clear,
  output logic             bus_start,
  output logic             bus_rw,
  output logic             bus_handshake_1,
  output logic             bus_handshake_2,
  output logic             data_oe,
  output logic             timeout_fault,
  output logic [CNT_W-1:0] xfer_count,
  output logic [2:0]       seq_state
);

  localparam logic [TMR_W-1:0] WD_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic req_s;
  logic dir_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk   (clk),
    .rst_n (reset),
    .d     (uP_handshake_1),
    .q     (req_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_dir (
    .clk   (clk),
    .rst_n (reset),
    .d     (uP_handshake_2),
    .q     (dir_s)
  );

  seq_state_t       state_q,     state_d;
  logic             issued_q,    issued_d;
  logic             bus_start_q, bus_start_d;
  logic             bus_rw_q,    bus_rw_d;
  logic             ack_q,       ack_d;
  logic             busy_q,      busy_d;
  logic             data_oe_q,   data_oe_d;
  logic             fault_q,     fault_d;
  logic [TMR_W-1:0] wd_q,        wd_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             wd_expired;
  logic             go_fault;

  assign wd_expired = (wd_q == WD_LAST);

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    bus_rw_d = bus_rw_q;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    go_fault = 1'b0;

    case (state_q)
      S_IDLE: begin
        issued_d = 1'b0;
        if (req_s) begin
          bus_rw_d = dir_s;
          wd_d     = '0;
          state_d  = S_WAIT_BUS;
        end
      end

      // bus_ready only counts once bus_start has actually been presented.
      S_WAIT_BUS: begin
        issued_d = 1'b1;
        if (issued_q && bus_ready) begin
          wd_d    = '0;
          state_d = S_ACK;
        end else if (wd_expired) begin
          go_fault = 1'b1;
          state_d  = S_FAULT;
        end else begin
          wd_d = wd_q + TMR_W'(1);
        end
      end

      S_ACK: begin
        if (!req_s) begin
          state_d = S_RELEASE;
        end else if (wd_expired) begin
          go_fault = 1'b1;
          state_d  = S_FAULT;
        end else begin
          wd_d = wd_q + TMR_W'(1);
        end
      end

      S_RELEASE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_IDLE;
      end

      // Hold here until the stale request is withdrawn so it is not replayed.
      S_FAULT: begin
        if (!req_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_fault) begin
      fault_d = 1'b1;
    end else if (fault_clear) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end

    bus_start_d = (state_q == S_WAIT_BUS) && !issued_q;
    ack_d       = (state_q == S_ACK);
    busy_d      = is_busy_state(state_q);
    data_oe_d   = (state_q == S_ACK) && bus_rw_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      issued_q    <= 1'b0;
      bus_start_q <= 1'b0;
      bus_rw_q    <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      data_oe_q   <= 1'b0;
      fault_q     <= 1'b0;
      wd_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      bus_start_q <= bus_start_d;
      bus_rw_q    <= bus_rw_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      data_oe_q   <= data_oe_d;
      fault_q     <= fault_d;
      wd_q        <= wd_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus_start       = bus_start_q;
  assign bus_rw          = bus_rw_q;
  assign bus_handshake_1 = ack_q;
  assign bus_handshake_2 = busy_q;
  assign data_oe         = data_oe_q;
  assign timeout_fault   = fault_q;
  assign xfer_count      = cnt_q;
  assign seq_state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_up_handshake_sequencer.sv
`default_nettype none
// tb_up_handshake_sequencer -- directed self-checking bench for up_handshake_sequencer.  rev 1.0
module tb_up_handshake_sequencer;

  localparam int SYNC = 2;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic       dir = 1'b0;
  logic       bus_ready = 1'b0;
  logic       fault_clear = 1'b0;
  logic       bus_start;
  logic       bus_rw;
  logic       ack;
  logic       busy;
  logic       data_oe;
  logic       timeout_fault;
  logic [3:0] xfer_count;
  logic [2:0] seq_state;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  up_handshake_sequencer #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO),
    .TMR_W          (8),
    .CNT_W          (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .uP_handshake_1  (req),
    .uP_handshake_2  (dir),
    .bus_ready       (bus_ready),
    .fault_clear     (fault_clear),
    .bus_start       (bus_start),
    .bus_rw          (bus_rw),
    .bus_handshake_1 (ack),
    .bus_handshake_2 (busy),
    .data_oe         (data_oe),
    .timeout_fault   (timeout_fault),
    .xfer_count      (xfer_count),
    .seq_state       (seq_state)
  );

  always @(negedge clk) begin
    if (bus_start === 1'b1) start_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return bus_start;
      1:       return ack;
      2:       return data_oe;
      3:       return timeout_fault;
      default: return (seq_state == 3'd0);
    endcase
  endfunction

  // Steps until the probed signal reaches val; n = steps taken, -1 on expiry.
  task automatic wait_sig(input int which, input logic val, input int max, output int n);
    n = 0;
    while (probe(which) !== val && n < max) begin
      step(1);
      n++;
    end
    if (probe(which) !== val) n = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    step(2);
    check_eq("reset_outputs", {bus_start, bus_rw, ack, busy, data_oe, timeout_fault, xfer_count, seq_state}, 0);
    reset = 1'b1;
    step(2);

    // 1: write, bus_ready three cycles after bus_start, request dropped five cycles after ack
    dir = 1'b0; bus_ready = 1'b0;
    req = 1'b1;
    wait_sig(0, 1'b1, 10, n);
    check_eq("wr_start_latency", n, SYNC + 2);
    check_eq("wr_bus_rw", bus_rw, 0);
    check_eq("wr_busy", busy, 1);
    step(1);
    check_eq("wr_start_single", bus_start, 0);
    step(2);
    bus_ready = 1'b1;
    wait_sig(1, 1'b1, 10, n);
    check_eq("wr_ack_latency", n, 2);
    bus_ready = 1'b0;
    check_eq("wr_data_oe", data_oe, 0);
    step(5);
    req = 1'b0;
    step(2);
    check_eq("wr_ack_held", ack, 1);
    wait_sig(1, 1'b0, 10, n);
    check_eq("wr_ack_fall", n, SYNC);
    check_eq("wr_count", xfer_count, 1);
    check_eq("wr_idle", seq_state, 0);
    check_eq("wr_start_pulses", start_cnt, 1);

    // 2: zero-wait read
    bus_ready = 1'b1; dir = 1'b1;
    step(SYNC + 1);
    req = 1'b1;
    wait_sig(0, 1'b1, 10, n);
    check_eq("rd_start_latency", n, SYNC + 2);
    wait_sig(1, 1'b1, 10, n);
    check_eq("rd_ack_latency", n, 2);
    check_eq("rd_data_oe_rise", data_oe, 1);
    check_eq("rd_bus_rw", bus_rw, 1);
    step(3);
    req = 1'b0;
    wait_sig(1, 1'b0, 10, n);
    check_eq("rd_ack_fall", n, SYNC + 2);
    check_eq("rd_data_oe_fall", data_oe, 0);
    check_eq("rd_count", xfer_count, 2);

    // 3: stalled bus
    bus_ready = 1'b0; dir = 1'b0;
    step(SYNC + 1);
    req = 1'b1;
    wait_sig(0, 1'b1, 10, n);
    check_eq("stall_start", n, SYNC + 2);
    wait_sig(3, 1'b1, 40, n);
    check_eq("stall_fault_time", n, TMO - 1);
    check_eq("stall_state", seq_state, 4);
    step(10);
    check_eq("stall_hold_state", seq_state, 4);
    check_eq("stall_no_ack", {ack, busy}, 0);
    req = 1'b0;
    wait_sig(4, 1'b1, 10, n);
    check_eq("stall_exit", n, SYNC + 1);
    check_eq("stall_count", xfer_count, 2);

    // 4: stalled release, then clear/set collision
    fault_clear = 1'b1;
    step(1);
    fault_clear = 1'b0;
    check_eq("clear_fault", timeout_fault, 0);
    check_eq("clear_fsm_idle", seq_state, 0);
    bus_ready = 1'b1; dir = 1'b1;
    step(SYNC + 1);
    req = 1'b1;
    wait_sig(1, 1'b1, 10, n);
    check_eq("rel_ack_latency", n, SYNC + 4);
    wait_sig(3, 1'b1, 40, n);
    check_eq("rel_fault_time", n, TMO - 1);
    check_eq("rel_state", seq_state, 4);
    step(1);
    check_eq("rel_ack_drop", {ack, data_oe}, 0);
    req = 1'b0;
    wait_sig(4, 1'b1, 10, n);
    check_eq("rel_exit", n, SYNC + 1);
    check_eq("rel_count", xfer_count, 2);
    step(SYNC + 1);
    req = 1'b1;
    wait_sig(1, 1'b1, 10, n);
    check_eq("coll_ack_latency", n, SYNC + 4);
    step(TMO - 2);
    fault_clear = 1'b1;
    step(1);
    fault_clear = 1'b0;
    check_eq("coll_set_wins", timeout_fault, 1);
    check_eq("coll_state", seq_state, 4);
    req = 1'b0;
    wait_sig(4, 1'b1, 10, n);
    check_eq("coll_exit", n, SYNC + 1);
    fault_clear = 1'b1;
    step(1);
    fault_clear = 1'b0;
    check_eq("lone_clear", timeout_fault, 0);

    // 5: reset while acknowledging
    step(SYNC + 1);
    req = 1'b1;
    wait_sig(1, 1'b1, 10, n);
    check_eq("rst_ack_before", n, SYNC + 4);
    reset = 1'b0;
    #1;
    check_eq("rst_async_outputs", {bus_start, bus_rw, ack, busy, data_oe, timeout_fault, xfer_count, seq_state}, 0);
    step(2);
    reset = 1'b1;
    wait_sig(0, 1'b1, 10, n);
    check_eq("rst_restart_latency", n, SYNC + 2);
    wait_sig(1, 1'b1, 10, n);
    check_eq("rst_restart_ack", n, 2);
    req = 1'b0;
    wait_sig(1, 1'b0, 10, n);
    check_eq("rst_restart_count", xfer_count, 1);

    // 6: counter wrap over 17 transactions from zero
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
    for (int i = 1; i <= 17; i++) begin
      req = 1'b1;
      wait_sig(1, 1'b1, 12, n);
      if (n < 0) check_eq("wrap_ack_timeout", i, 0);
      req = 1'b0;
      wait_sig(1, 1'b0, 12, n);
      if (n < 0) check_eq("wrap_rel_timeout", i, 0);
      if (i == 15) check_eq("wrap_at_15", xfer_count, 15);
      if (i == 16) check_eq("wrap_to_0", xfer_count, 0);
      if (i == 17) check_eq("wrap_end_1", xfer_count, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/up_handshake_sequencer.md
Name: uP_handshake_sequencer

Overview:
Sequences the four-phase request/acknowledge handshake between the external microprocessor and the FPGA internal register bus. Synchronises the uP strobes, launches one internal bus transaction per request and drives the acknowledge and busy lines back to the uP. A watchdog detects stalled transactions or stalled releases, and a sticky fault flag is exported for the supervisor LEDs and status register. Sits between the uP interface pins and the register bank; its outputs are the signals the supervisor displays.

Parameters:
SYNC_STAGES, 2, flip-flop depth of input synchronisers (>=2)
TIMEOUT_CYCLES, 50000, watchdog limit in clk cycles (1 ms at 50 MHz); must be >=2
TMR_W, 16, watchdog counter width; must satisfy 2**TMR_W > TIMEOUT_CYCLES
CNT_W, 16, transaction counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
uP_handshake_1  in  1  async uP transfer request, 1 = request
uP_handshake_2  in  1  async uP direction, 1 = read (FPGA->uP), 0 = write
bus_ready  in  1  register bank transaction complete, level, sampled only in S_WAIT_BUS
fault_clear  in  1  one-cycle pulse, clears timeout_fault
bus_start  out  1  one-cycle pulse, starts internal transaction
bus_rw  out  1  latched direction for current transaction
bus_handshake_1  out  1  acknowledge to uP
bus_handshake_2  out  1  busy to uP (pad tri-state is handled outside this block)
data_oe  out  1  enable for the uP data-bus drivers, high only during a read acknowledge
timeout_fault  out  1  sticky watchdog fault
xfer_count  out  CNT_W  completed transactions, wraps modulo 2**CNT_W
seq_state  out  3  current state encoding, for debug

Behaviour:
- All outputs registered. While reset=0: every output is 0, state is S_IDLE, synchronisers and counters are cleared.
- Reset asserted mid-transaction aborts the transaction immediately. No bus_start or acknowledge appears until a fresh request.
- req_s and dir_s are the synchronised versions of uP_handshake_1 and uP_handshake_2, each SYNC_STAGES deep.
- uP contract: direction must be stable at least SYNC_STAGES cycles before the request.
- States: S_IDLE=0, S_WAIT_BUS=1, S_ACK=2, S_RELEASE=3, S_FAULT=4.
- S_IDLE:
  - ack=0, busy=0, data_oe=0.
  - If req_s=1: latch bus_rw<=dir_s, go to S_WAIT_BUS, clear the watchdog.
- S_WAIT_BUS:
  - bus_start=1 on the first cycle only; busy=1.
  - bus_ready is sampled from that first cycle, so zero-wait slaves are supported.
  - If bus_ready=1: go to S_ACK.
- S_ACK:
  - bus_handshake_1=1, busy=1, data_oe=bus_rw. Watchdog cleared on entry.
  - If req_s=0: go to S_RELEASE.
- S_RELEASE: single cycle.
  - ack=0, busy=0, data_oe=0.
  - xfer_count increments. The counter wraps; all-ones+1 gives 0.
  - Go to S_IDLE. A new request is recognised no earlier than the following cycle.
- Watchdog:
  - Counts in S_WAIT_BUS and S_ACK.
  - When the count reaches TIMEOUT_CYCLES-1 without the exit condition: go to S_FAULT and set timeout_fault.
  - If the exit condition and the timeout coincide, the exit condition wins.
- S_FAULT:
  - ack=0, busy=0, data_oe=0, no bus_start.
  - Go to S_IDLE only after req_s=0 has been sampled, so the stale request is not restarted.
  - xfer_count is not incremented.
- timeout_fault:
  - Cleared by a fault_clear pulse.
  - If set and clear occur in the same cycle, set wins.
  - fault_clear does not affect the FSM.
- Latency: if uP_handshake_1 rises before edge k, bus_start is high in the cycle after edge k+SYNC_STAGES+1.
- Latency: with zero-wait bus_ready, bus_handshake_1 rises two cycles after bus_start.
- A request held high does not retrigger: exactly one transaction per rising request.

Decomposition:
- Package types:
  - typedef enum logic [2:0] seq_state_t with the five states.
  - Constant HS_TIMEOUT_DEFAULT=50000 placed in global_constants.sv.
- Sub-module sync_ff (parameter STAGES, width 1), instanced twice, for uP_handshake_1 and uP_handshake_2.
- The FSM, watchdog and counter stay in uP_handshake_sequencer.

Test Plan:
1. Write: dir=0, request high, bus_ready returned 3 cycles after bus_start, request dropped 5 cycles after ack -> bus_start pulses once at SYNC_STAGES+2 cycles; bus_rw=0; ack high until 2 cycles after request falls; data_oe stays 0; xfer_count 0->1.
2. Read with zero-wait: bus_ready tied 1, dir=1 -> ack and data_oe rise 2 cycles after bus_start and fall together; xfer_count increments.
3. Stalled bus: TIMEOUT_CYCLES=20, bus_ready held 0 -> S_FAULT after 20 cycles in S_WAIT_BUS; timeout_fault=1; no ack; request held 10 more cycles keeps S_FAULT; request drop -> S_IDLE; xfer_count unchanged.
4. Stalled release: request held high past ack, timeout 20 -> fault after 20 cycles in S_ACK; ack drops; exit on request low. Then fault_clear and a new fault on the same cycle -> timeout_fault stays 1; a lone fault_clear -> 0.
5. Reset mid-transfer: assert reset while in S_ACK -> all outputs 0 asynchronously; release reset with request still high -> a new transaction starts.
6. Wrap: CNT_W=4, 17 back-to-back transactions -> xfer_count passes 15->0 and ends at 1.
